// File: rtl/fpa_control_fsm.sv
// fpa_control_fsm
// Sequencing controller for the FloatingPointAdder datapath. It walks one
// addition through IDLE -> ALIGN -> NORM -> ROUND -> DONE. A rounding
// overflow allows one extra NORM/ROUND pass. Special operands (Inf/NaN
// exponent, or both operands zero) skip straight to DONE.
//
// Ports
//   Clock, Reset          rising-edge clock, async active-high reset
//   Go                    start request, sampled only in IDLE
//   ExpSet, ExpDiff       ExpALU compare result and |expA - expB|
//   ExpA, ExpB            raw exponents, for special-case detection
//   FracAZero, FracBZero  fraction-is-zero flags
//   FFOValid, RoundOvf    Normalizer leading-one found / rounding carry-out
//   SelExpMux, SelSRMuxL, SelSRMuxG   pipe0 selects (Mealy, in the Go cycle)
//   ShiftRightAmount      saturated pre-add alignment shift, held until next Go
//   SelManMuxR, SelExpMuxR            rounding-loop selects (Mealy, in ROUND)
//   SREn                  normaliser shift enable (NORM)
//   Busy, Done            state != IDLE / one-cycle completion pulse
//   Special, ZeroRes      result qualifiers, valid with Done
module fpa_control_fsm #(
    parameter int SHIFT_W   = 6,
    parameter int SHIFT_SAT = 48,
    parameter int EXP_W     = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Go,
    input  logic               ExpSet,
    input  logic [EXP_W-1:0]   ExpDiff,
    input  logic [EXP_W-1:0]   ExpA,
    input  logic [EXP_W-1:0]   ExpB,
    input  logic               FracAZero,
    input  logic               FracBZero,
    input  logic               FFOValid,
    input  logic               RoundOvf,
    output logic               SelExpMux,
    output logic               SelSRMuxL,
    output logic               SelSRMuxG,
    output logic [SHIFT_W-1:0] ShiftRightAmount,
    output logic               SelManMuxR,
    output logic               SelExpMuxR,
    output logic               SREn,
    output logic               Busy,
    output logic               Done,
    output logic               Special,
    output logic               ZeroRes
);

    localparam logic [EXP_W-1:0]   SAT_E   = EXP_W'(SHIFT_SAT);
    localparam logic [SHIFT_W-1:0] SAT_S   = SHIFT_W'(SHIFT_SAT);
    localparam logic [EXP_W-1:0]   EXP_MAX = '1;

    typedef enum logic [2:0] {IDLE, ALIGN, NORM, ROUND, DONE} state_t;

    state_t             state;
    logic               reloop;
    logic               accept;
    logic               renorm;
    logic               special_in;
    logic [SHIFT_W-1:0] shamt;

    // The pipe0 registers capture on the Go edge itself, so their selects
    // must be valid combinationally while Go is high in IDLE.
    assign accept    = (state == IDLE) & Go & ~Reset;
    assign SelExpMux = accept & ExpSet;
    assign SelSRMuxG = accept & ExpSet;
    assign SelSRMuxL = accept & ~ExpSet;

    // Likewise pipe1 recaptures the rounded value on the edge leaving ROUND.
    assign renorm     = (state == ROUND) & RoundOvf & ~reloop;
    assign SelManMuxR = renorm;
    assign SelExpMuxR = renorm;

    // Inf/NaN on either side, or 0 + 0: the datapath result is bypassed.
    assign special_in = (ExpA == EXP_MAX) | (ExpB == EXP_MAX) |
                        ((ExpA == '0) & FracAZero & (ExpB == '0) & FracBZero);

    // Shifting the 48-bit mantissa by 48 or more leaves only sticky bits.
    assign shamt = (ExpDiff < SAT_E) ? ExpDiff[SHIFT_W-1:0] : SAT_S;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state            <= IDLE;
            reloop           <= 1'b0;
            ShiftRightAmount <= '0;
            SREn             <= 1'b0;
            Busy             <= 1'b0;
            Done             <= 1'b0;
            Special          <= 1'b0;
            ZeroRes          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Go) begin
                        ShiftRightAmount <= shamt;
                        Busy             <= 1'b1;
                        if (special_in) begin
                            state   <= DONE;
                            Special <= 1'b1;
                            Done    <= 1'b1;
                        end else begin
                            state <= ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    state <= NORM;
                    SREn  <= 1'b1;
                end
                NORM: begin
                    SREn <= 1'b0;
                    if (!FFOValid) begin
                        // Exact cancellation: nothing to normalise or round.
                        state   <= DONE;
                        ZeroRes <= 1'b1;
                        Done    <= 1'b1;
                    end else begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    if (renorm) begin
                        state  <= NORM;
                        reloop <= 1'b1;
                        SREn   <= 1'b1;
                    end else begin
                        state <= DONE;
                        Done  <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    Done    <= 1'b0;
                    Busy    <= 1'b0;
                    reloop  <= 1'b0;
                    Special <= 1'b0;
                    ZeroRes <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    SREn    <= 1'b0;
                    Done    <= 1'b0;
                    Busy    <= 1'b0;
                    reloop  <= 1'b0;
                    Special <= 1'b0;
                    ZeroRes <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpa_control_fsm.sv
// Self-checking bench for fpa_control_fsm. Each operation is planned up front
// (operands, cancellation, rounding overflows); the plan yields a per-cycle
// timeline of expected outputs that a single negedge process compares.
module tb_fpa_control_fsm;

    logic       Clock = 1'b0;
    logic       Reset, Go, ExpSet, FracAZero, FracBZero, FFOValid, RoundOvf;
    logic [7:0] ExpDiff, ExpA, ExpB;
    logic       SelExpMux, SelSRMuxL, SelSRMuxG, SelManMuxR, SelExpMuxR;
    logic       SREn, Busy, Done, Special, ZeroRes;
    logic [5:0] ShiftRightAmount;

    fpa_control_fsm #(.SHIFT_W(6), .SHIFT_SAT(48), .EXP_W(8)) dut (
        .Clock(Clock), .Reset(Reset), .Go(Go), .ExpSet(ExpSet), .ExpDiff(ExpDiff),
        .ExpA(ExpA), .ExpB(ExpB), .FracAZero(FracAZero), .FracBZero(FracBZero),
        .FFOValid(FFOValid), .RoundOvf(RoundOvf), .SelExpMux(SelExpMux),
        .SelSRMuxL(SelSRMuxL), .SelSRMuxG(SelSRMuxG),
        .ShiftRightAmount(ShiftRightAmount), .SelManMuxR(SelManMuxR),
        .SelExpMuxR(SelExpMuxR), .SREn(SREn), .Busy(Busy), .Done(Done),
        .Special(Special), .ZeroRes(ZeroRes)
    );

    always #5 Clock = ~Clock;

    int   checks = 0;
    int   failures = 0;
    logic chk_en = 1'b0;

    logic       e_selexp, e_sell, e_selg, e_selman, e_selexpr;
    logic       e_sren, e_busy, e_done, e_special, e_zero;
    logic [5:0] e_sra;
    logic [5:0] sra_model;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clock) begin
        if (chk_en) begin
            chk("SelExpMux",  32'(SelExpMux),  32'(e_selexp));
            chk("SelSRMuxL",  32'(SelSRMuxL),  32'(e_sell));
            chk("SelSRMuxG",  32'(SelSRMuxG),  32'(e_selg));
            chk("SelManMuxR", 32'(SelManMuxR), 32'(e_selman));
            chk("SelExpMuxR", 32'(SelExpMuxR), 32'(e_selexpr));
            chk("SREn",       32'(SREn),       32'(e_sren));
            chk("Busy",       32'(Busy),       32'(e_busy));
            chk("Done",       32'(Done),       32'(e_done));
            chk("Special",    32'(Special),    32'(e_special));
            chk("ZeroRes",    32'(ZeroRes),    32'(e_zero));
            chk("ShiftRightAmount", 32'(ShiftRightAmount), 32'(e_sra));
        end
    end

    function automatic logic [5:0] sat(input int d);
        return (d < 48) ? 6'(d) : 6'd48;
    endfunction

    task automatic set_idle_exp();
        e_selexp = 0; e_sell = 0; e_selg = 0; e_selman = 0; e_selexpr = 0;
        e_sren = 0; e_busy = 0; e_done = 0; e_special = 0; e_zero = 0;
        e_sra = sra_model;
    endtask

    task automatic rand_inputs();
        ExpSet    = 1'($urandom);
        ExpDiff   = 8'($urandom);
        ExpA      = 8'($urandom);
        ExpB      = 8'($urandom);
        FracAZero = 1'($urandom);
        FracBZero = 1'($urandom);
        FFOValid  = 1'($urandom);
        RoundOvf  = 1'($urandom);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock); #1;
            rand_inputs();
            Go = 1'b0;
            set_idle_exp();
        end
    endtask

    // Cycle k=0 is the Go cycle; Done is expected in cycle L.
    task automatic run_op(input int a, input int b, input logic fza, input logic fzb,
                          input logic zero, input logic ovf1, input logic ovf2,
                          input logic gohold, input int abort_at,
                          input int lat_lit, input int sra_lit);
        logic       special;
        int         L, diff, done_at;
        logic [5:0] s;
        special = (a == 255) || (b == 255) || (a == 0 && fza && b == 0 && fzb);
        diff    = (a >= b) ? a - b : b - a;
        s       = sat(diff);
        L       = special ? 1 : zero ? 3 : ovf1 ? 6 : 4;
        done_at = -1;
        for (int k = 0; k <= L; k++) begin
            @(posedge Clock); #1;
            rand_inputs();
            set_idle_exp();
            if (k == 0) begin
                Go = 1'b1;
                ExpA = 8'(a); ExpB = 8'(b); FracAZero = fza; FracBZero = fzb;
                ExpSet = (a >= b); ExpDiff = 8'(diff);
                e_selexp = ExpSet; e_selg = ExpSet; e_sell = !ExpSet;
            end else begin
                Go = gohold ? 1'b1 : 1'($urandom);
                sra_model = s;
                e_busy = 1'b1;
                e_sra  = s;
                if (k == 2) FFOValid = !zero;
                if (k == 4) FFOValid = 1'b1;
                if (k == 3) RoundOvf = ovf1;
                if (k == 5) RoundOvf = ovf2;
                e_sren    = !special && ((k == 2) || (k == 4 && ovf1 && !zero));
                e_selman  = !special && !zero && ovf1 && (k == 3);
                e_selexpr = e_selman;
                e_done    = (k == L);
                e_special = (k == L) && special;
                e_zero    = (k == L) && zero && !special;
            end
            if (k == abort_at) begin
                Go = 1'b0;
                Reset = 1'b1;
                sra_model = '0;
                set_idle_exp();
                #1;
                chk("abort_busy", 32'(Busy), 32'd0);
                chk("abort_sren", 32'(SREn), 32'd0);
                chk("abort_sra", 32'(ShiftRightAmount), 32'd0);
                @(posedge Clock); #1;
                Reset = 1'b0;
                return;
            end
            @(negedge Clock);
            if (Done === 1'b1 && done_at < 0) done_at = k;
            if (k == 1 && sra_lit >= 0) chk("sra_literal", 32'(ShiftRightAmount), 32'(sra_lit));
        end
        if (lat_lit >= 0) chk("latency", 32'(done_at), 32'(lat_lit));
    endtask

    initial begin
        int a, b, r;
        logic fza, fzb;
        Reset = 1'b1;
        rand_inputs();
        Go = 1'b0;
        sra_model = '0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        chk("rst_busy",    32'(Busy), 32'd0);
        chk("rst_done",    32'(Done), 32'd0);
        chk("rst_sren",    32'(SREn), 32'd0);
        chk("rst_sra",     32'(ShiftRightAmount), 32'd0);
        chk("rst_special", 32'(Special), 32'd0);
        chk("rst_zero",    32'(ZeroRes), 32'd0);
        @(posedge Clock); #1;
        Reset = 1'b0;
        set_idle_exp();
        chk_en = 1'b1;
        idle_cycles(2);

        // Directed cases with hand-computed latency / shift amount.
        run_op(130, 127, 0, 0, 0, 0, 0, 0, -1, 4, 3);
        run_op(10, 200, 0, 0, 0, 0, 0, 0, -1, 4, 48);
        idle_cycles(1);
        run_op(100, 90, 1, 0, 0, 1, 1, 0, -1, 6, 10);
        run_op(255, 3, 0, 1, 0, 0, 0, 0, -1, 1, 48);
        run_op(0, 0, 1, 1, 0, 0, 0, 0, -1, 1, 0);
        run_op(77, 77, 0, 0, 1, 0, 0, 0, -1, 3, 0);
        run_op(20, 60, 0, 0, 0, 1, 0, 0, -1, 6, 40);
        // Go held high: back-to-back operations, Done every 5 cycles.
        for (int i = 0; i < 3; i++) run_op(50 + i, 40, 0, 0, 0, 0, 0, 1, -1, 4, 10 + i);
        // Reset in NORM abandons the operation; no Done afterwards.
        run_op(140, 120, 0, 0, 0, 0, 0, 0, 2, -1, -1);
        idle_cycles(6);

        for (int i = 0; i < 250; i++) begin
            idle_cycles(int'($urandom_range(0, 2)));
            r   = int'($urandom_range(0, 7));
            a   = int'($urandom_range(0, 254));
            b   = int'($urandom_range(0, 254));
            fza = 1'($urandom);
            fzb = 1'($urandom);
            if (r == 0) a = 255;
            if (r == 1) b = 255;
            if (r == 2) begin a = 0; b = 0; fza = 1'b1; fzb = 1'b1; end
            run_op(a, b, fza, fzb, ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0), -1, -1, -1);
        end
        idle_cycles(2);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpa_control_fsm.md
Name: fpa_control_fsm

Overview:
- Sequencing controller for the FloatingPointAdder datapath; fills the adder's control-module slot.
- Drives the exponent and mantissa mux selects, the pre-add right-shift amount, normaliser enable and rounding-loop selects.
- Sequences one addition from Go to Done, including one rounding-overflow renormalisation pass and special-operand bypass.
- Consumes ExpALU outputs plus Normalizer/rounding status.

Parameters:
SHIFT_W, 6, width of ShiftRightAmount (48-bit pre-add shifter)
SHIFT_SAT, 48, saturation value for the pre-add shift
EXP_W, 8, exponent width (IEEE single)

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
Go  input  1  start request; sampled only in IDLE
ExpSet  input  1  from ExpALU: 1 = AddendA.exp >= AddendB.exp
ExpDiff  input  EXP_W  from ExpALU: |AddendA.exp - AddendB.exp|
ExpA  input  EXP_W  AddendA.exp, for special-case detect
ExpB  input  EXP_W  AddendB.exp
FracAZero  input  1  AddendA.frac == 0
FracBZero  input  1  AddendB.frac == 0
FFOValid  input  1  Normalizer: sum has a leading one (0 = exact cancellation)
RoundOvf  input  1  rounding produced mantissa carry-out
SelExpMux  output  1  1 = AddendA.exp to pipe0
SelSRMuxL  output  1  1 = AddendA is the small operand (to shifter)
SelSRMuxG  output  1  1 = AddendA is the large operand (to BigALU)
ShiftRightAmount  output  SHIFT_W  pre-add right shift
SelManMuxR  output  1  1 = rounded mantissa/sign into pipe1
SelExpMuxR  output  1  1 = rounded exponent into pipe1
SREn  output  1  normaliser shift enable
Busy  output  1  high whenever state != IDLE
Done  output  1  one-cycle completion pulse
Special  output  1  valid with Done: special-case bypass result
ZeroRes  output  1  valid with Done: exact-zero result

Behaviour:
- States: IDLE, ALIGN, NORM, ROUND, DONE. Reset asynchronously forces IDLE, clears the reloop flag and drives all outputs to 0. Reset mid-operation abandons the operation with no Done.
- IDLE, Go=1 (Mealy, same cycle): SelExpMux=SelSRMuxG=ExpSet and SelSRMuxL=~ExpSet, so the pipe0 registers capture at this edge.
  - ShiftRightAmount is registered at the same edge: ExpDiff if ExpDiff < SHIFT_SAT, else SHIFT_SAT.
  - Special-case detect: special = (ExpA==255)|(ExpB==255)|(ExpA==0&FracAZero&ExpB==0&FracBZero). If special, next state is DONE with Special latched to 1; otherwise next state is ALIGN.
- IDLE, Go=0: all selects are 0; remain in IDLE.
- ALIGN: SelManMuxR=SelExpMuxR=0, so pipe1 captures mantSum and the pre-norm exponent. Next state is NORM.
- NORM: SREn=1.
  - FFOValid=0: latch ZeroRes=1; next state is DONE.
  - Otherwise: next state is ROUND.
- ROUND:
  - RoundOvf=1 and reloop=0: SelManMuxR=SelExpMuxR=1, set reloop; next state is NORM.
  - Otherwise: next state is DONE.
- DONE: Done=1 for exactly one cycle, with Special/ZeroRes held valid. Next state is IDLE; reloop, Special and ZeroRes are cleared on exit.
- Latency: Done is high in the 4th cycle after the Go edge on the normal path, the 6th with reloop, and the 1st for special cases.
- At most one renormalisation pass; a second RoundOvf goes to DONE.
- Go while Busy is ignored and not queued.
- Go asserted in the same cycle Done is high is ignored, because the FSM is in DONE, not IDLE.
- ShiftRightAmount holds its value until the next accepted Go.

Test Plan:
- Reset asserted mid-NORM -> next cycle state IDLE; Busy=0, Done=0, SREn=0, ShiftRightAmount=0; no Done afterwards.
- ExpA=130, ExpB=127, ExpSet=1, ExpDiff=3, Go pulse -> SelExpMux=1, SelSRMuxG=1, SelSRMuxL=0 in the Go cycle; ShiftRightAmount=3; SREn in cycle 2; Done in cycle 4; Special=0, ZeroRes=0.
- ExpA=10, ExpB=200, ExpSet=0, ExpDiff=190 -> ShiftRightAmount=48; SelSRMuxL=1 in the Go cycle.
- Normal operation, RoundOvf=1 in both ROUND visits -> SelManMuxR=SelExpMuxR=1 in the first ROUND only; NORM re-entered once; Done in cycle 6.
- ExpA=255 -> Done in cycle 1 with Special=1, SREn never asserted.
- Both operands zero -> Done in cycle 1 with Special=1.
- FFOValid=0 in NORM -> Done in cycle 3 with ZeroRes=1.
- Go held high continuously -> one operation per IDLE visit: Done every 5 cycles (4 latency + 1 IDLE).
